// File: rtl/clock_divider_multi.sv
// clock_divider_multi: NUM_CHANNELS runtime-programmable divided clocks with ticks and a lock status.
// Optional feature macro CLKDIV_PHASE_EN: applied configurations preload the channel counter with cfg_phase.
module clock_divider_multi #(
    parameter int NUM_CHANNELS = 4,
    parameter int DIV_W = 16,
    parameter int DEFAULT_DIV = 2,
    parameter int LOCK_CYCLES = 16,
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CH_W-1:0]         cfg_chan,
    input  logic [DIV_W-1:0]        cfg_div,
    input  logic [DIV_W-1:0]        cfg_phase,
    output logic [NUM_CHANNELS-1:0] outclk,
    output logic [NUM_CHANNELS-1:0] tick,
    output logic                    locked
);
    localparam int LC_W = $clog2(LOCK_CYCLES + 1);

    logic [DIV_W-1:0]        r_cnt [NUM_CHANNELS];
    logic [DIV_W-1:0]        r_div [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] r_outclk, r_tick;
    logic                    r_run, r_pend, r_ready, r_locked;
    logic [CH_W-1:0]         r_pchan;
    logic [DIV_W-1:0]        r_pdiv;
    logic [LC_W-1:0]         r_lc;

    logic [DIV_W-1:0]        w_ncnt [NUM_CHANNELS];
    logic [DIV_W-1:0]        w_ndiv [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] w_apply, w_ntick, w_nclk;
    logic [DIV_W-1:0]        w_phase;
    logic [LC_W-1:0]         w_lc_n;
    logic                    w_take;

`ifdef CLKDIV_PHASE_EN
    logic [DIV_W-1:0]        r_pphase;
    assign w_phase = (r_pphase < r_pdiv) ? r_pphase : '0;
`else
    logic                    w_unused_phase;
    assign w_unused_phase = ^cfg_phase;
    assign w_phase = '0;
`endif

    // Out-of-range channel requests complete the handshake but never occupy the pending slot.
    assign w_take = cfg_valid && r_ready && (32'(cfg_chan) < NUM_CHANNELS);

    genvar i;
    for (i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic [DIV_W:0] w_half;
        assign w_apply[i] = r_pend && (r_pchan == CH_W'(i)) &&
                            ((r_div[i] <= DIV_W'(1)) || (r_cnt[i] == r_div[i] - DIV_W'(1)));
        assign w_ndiv[i]  = w_apply[i] ? r_pdiv : r_div[i];
        assign w_ncnt[i]  = w_apply[i] ? w_phase :
                            ((r_div[i] == '0) || !r_run || (r_cnt[i] == r_div[i] - DIV_W'(1))) ? '0 :
                            r_cnt[i] + DIV_W'(1);
        assign w_half     = ({1'b0, w_ndiv[i]} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
        assign w_ntick[i] = (w_ndiv[i] != '0) && (w_ncnt[i] == '0);
        assign w_nclk[i]  = (w_ndiv[i] != '0) && ({1'b0, w_ncnt[i]} < w_half);
    end

    // Lock counter is cleared by an accepted request, frozen while it waits, and resumes on application.
    assign w_lc_n = w_take ? '0 :
                    (r_pend && !(|w_apply)) ? r_lc :
                    (r_lc == LC_W'(LOCK_CYCLES)) ? r_lc : r_lc + LC_W'(1);

    // Channel counters, registered outputs, pending slot and lock status.
    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_cnt[c] <= '0;
                r_div[c] <= DIV_W'(DEFAULT_DIV);
            end
            r_outclk <= '0;
            r_tick   <= '0;
            r_run    <= 1'b0;
            r_pend   <= 1'b0;
            r_ready  <= 1'b0;
            r_locked <= 1'b0;
            r_pchan  <= '0;
            r_pdiv   <= '0;
            r_lc     <= '0;
`ifdef CLKDIV_PHASE_EN
            r_pphase <= '0;
`endif
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_cnt[c] <= w_ncnt[c];
                r_div[c] <= w_ndiv[c];
            end
            r_outclk <= w_nclk;
            r_tick   <= w_ntick;
            r_run    <= 1'b1;
            r_ready  <= !r_pend && !w_take;
            r_lc     <= w_lc_n;
            r_locked <= (w_lc_n == LC_W'(LOCK_CYCLES));
            if (w_take) begin
                r_pend  <= 1'b1;
                r_pchan <= cfg_chan;
                r_pdiv  <= cfg_div;
`ifdef CLKDIV_PHASE_EN
                r_pphase <= cfg_phase;
`endif
            end else if (|w_apply) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign outclk    = r_outclk;
    assign tick      = r_tick;
    assign cfg_ready = r_ready;
    assign locked    = r_locked;
endmodule

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: randomized bench against a cycle-schedule reference model of clock_divider_multi.
module tb_clock_divider_multi;
    localparam int N = 5;
    localparam int LOCK = 16;
    localparam int DEF = 2;

    logic           refclk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [2:0]     cfg_chan = '0;
    logic [15:0]    cfg_div = '0;
    logic [15:0]    cfg_phase = '0;
    logic [N-1:0]   outclk, tick;
    logic           locked;

    clock_divider_multi #(
        .NUM_CHANNELS(N), .DIV_W(16), .DEFAULT_DIV(DEF), .LOCK_CYCLES(LOCK)
    ) dut (
        .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
        .outclk(outclk), .tick(tick), .locked(locked)
    );

    always #5 refclk = ~refclk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    bit m_rst = 1'b1;
    bit m_pend = 1'b0;
    bit m_ready = 1'b0;
    int m_d [N];
    int m_t0 [N];
    int m_lock0 = 0;
    int m_apply = -10;
    int m_x = 0;
    int m_pchan = 0;
    int m_pd = 0;
    int m_pp = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Each channel is modelled by its divisor and the cycle at which its current period started;
    // a request is scheduled onto the channel's next tick cycle (or the next cycle if div<=1).
    task automatic step(input bit r, input bit v, input int ch, input int dv, input int ph);
        logic [N-1:0] e_clk, e_tick;
        bit e_rdy, e_lock;
        int k, p;
        rst = r;
        cfg_valid = v;
        cfg_chan = 3'(ch);
        cfg_div = 16'(dv);
        cfg_phase = 16'(ph);
        @(posedge refclk);
        #1;
        cyc++;
        e_clk = '0;
        e_tick = '0;
        e_rdy = 1'b0;
        e_lock = 1'b0;
        if (r) begin
            m_rst = 1'b1;
            m_pend = 1'b0;
        end else begin
            if (m_rst) begin
                m_rst = 1'b0;
                for (int c = 0; c < N; c++) begin
                    m_d[c] = DEF;
                    m_t0[c] = cyc;
                end
                m_lock0 = cyc;
                m_apply = -10;
            end else begin
                if (m_pend && cyc == m_x) begin
`ifdef CLKDIV_PHASE_EN
                    p = (m_pp < m_pd) ? m_pp : 0;
`else
                    p = 0;
`endif
                    m_d[m_pchan] = m_pd;
                    m_t0[m_pchan] = cyc - p;
                    m_pend = 1'b0;
                    m_apply = cyc;
                    m_lock0 = cyc;
                end
                if (v && m_ready && ch < N) begin
                    m_pend = 1'b1;
                    m_pchan = ch;
                    m_pd = dv;
                    m_pp = ph;
                    m_x = (m_d[ch] <= 1) ? cyc + 1 : cyc + m_d[ch] - (cyc - m_t0[ch]) % m_d[ch];
                end
            end
            for (int c = 0; c < N; c++) begin
                if (m_d[c] != 0) begin
                    k = (cyc - m_t0[c]) % m_d[c];
                    e_tick[c] = (k == 0);
                    e_clk[c] = (k < (m_d[c] + 1) / 2);
                end
            end
            e_rdy = !m_pend && cyc != m_apply;
            e_lock = !m_pend && (cyc - m_lock0 >= LOCK - 1);
        end
        m_ready = e_rdy;
        check("outclk", 32'(outclk), 32'(e_clk));
        check("tick", 32'(tick), 32'(e_tick));
        check("cfg_ready", 32'(cfg_ready), 32'(e_rdy));
        check("locked", 32'(locked), 32'(e_lock));
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        repeat (3) step(1'b1, 1'b1, 1, 5, 0);
        idle(20);
        step(1'b0, 1'b1, 1, 5, 0);
        idle(25);
        step(1'b0, 1'b1, 2, 0, 0);
        idle(6);
        step(1'b0, 1'b1, 2, 1, 0);
        idle(20);
        step(1'b0, 1'b1, 7, 3, 0);
        idle(6);
        step(1'b0, 1'b1, 1, 3, 0);
        idle(1);
        step(1'b1, 1'b1, 1, 4, 0);
        idle(20);
        step(1'b0, 1'b1, 3, 8, 6);
        idle(24);
        step(1'b0, 1'b1, 3, 8, 9);
        idle(24);
        step(1'b0, 1'b1, 4, 7, 3);
        idle(24);
        for (int j = 0; j < 4000; j++)
            step($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 9)), int'($urandom_range(0, 10)));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
